counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Command-driven controller that sequences the 8-bit simple counter in the Tiny Tapeout user design. It accepts load / step-up / step-down / abort commands over a valid/ready interface and drives the counter's load, enable and direction controls with a programmable step rate. It sits between the `ui_in` decode logic and the counter datapath, and reports completion with a one-cycle `done` pulse.

## Interface

- `PRESCALE_W`, default 8: width of the step-rate prescaler.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_op`  in  2  operation: 00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 ABORT.
- `cmd_data`  in  8  LOAD: value to load; STEP_*: step count N (0–255); ABORT: ignored.
- `prescale`  in  PRESCALE_W  step period minus one, in cycles; sampled at command accept.
- `cnt_load`  out  1  one-cycle load strobe to the counter.
- `cnt_load_val`  out  8  load value; meaningful only while `cnt_load`=1.
- `cnt_en`  out  1  one-cycle count-enable strobe, one per step.
- `cnt_up`  out  1  direction: 1 up, 0 down.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: 1 if the command ended by ABORT.

## Operation

- All outputs are registered. `cmd_ready` is the only output that is combinational, and it depends on state and `cmd_op` only, never on `cmd_valid`.
- A command is accepted on a rising edge where `cmd_valid`=1 and `cmd_ready`=1.
- `cmd_ready` = 1 in IDLE. In RUN, `cmd_ready` = 1 only when `cmd_op`=ABORT. In LOAD and DONE, `cmd_ready` = 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE → LOAD on an accepted LOAD command: latch `cmd_data` into `cnt_load_val`.
- IDLE → RUN on an accepted STEP_* command with N>0:
  - Latch N into an 8-bit `remaining` counter.
  - Latch `prescale` into P.
  - Set `cnt_up` = (op==STEP_UP). `cnt_up` holds its value until the next accepted STEP_* command.
- IDLE → DONE on an accepted STEP_* command with N=0, or on ABORT. ABORT in IDLE produces `aborted`=1.
- LOAD: assert `cnt_load` for exactly one cycle, then go to DONE.
- RUN:
  - The prescale counter `pc` starts at 0 and increments each cycle.
  - When `pc`==P: assert `cnt_en` for one cycle, clear `pc`, and decrement `remaining`.
  - On the step where `remaining` goes 1→0, go to DONE.
- RUN + accepted ABORT:
  - ABORT has priority; `cnt_en` is 0 in the following cycle even if a step was due.
  - Next state is DONE with `aborted`=1.
  - Steps already issued are not undone.
- DONE: `done`=1 for one cycle, with `aborted` valid in the same cycle. Then go to IDLE.
- Arithmetic: `remaining` is 8-bit and never underflows (N=0 bypasses RUN). `pc` is PRESCALE_W bits and compares by equality, so P=all-ones is legal. Counter wrap-around is the counter's concern; the sequencer does not observe the counter value.
- Reset: on any edge with `rst`=1, go to IDLE. All outputs become 0 at that edge, regardless of the current state, including mid-RUN. A command is never accepted on a reset edge.

## Timing

- Cycle numbering: accept edge = cycle 0; outputs listed appear in the cycle after that edge.
- LOAD: `cnt_load`=1 in cycle 1; `done` in cycle 2. `busy`=1 in cycles 1–2.
- STEP_* N>0: step k (k=1..N) has `cnt_en`=1 in cycle k·(P+1). `done` in cycle N·(P+1)+1.
- STEP_* N=0 or ABORT in IDLE: `done` in cycle 1.
- ABORT accepted in RUN at edge A: `cnt_en`=0 from cycle A+1; `done`=`aborted`=1 in cycle A+1.
- The earliest next command is accepted at the edge ending the DONE cycle +1 (the first IDLE cycle). There are no back-to-back accepts.

## Test plan

- Reset during RUN: STEP_UP N=200, P=3; assert `rst` for 1 cycle after 5 steps → all outputs 0 next cycle, `cmd_ready`=1, no further `cnt_en`.
- LOAD `cmd_data`=0xA5 → `cnt_load`=1 with `cnt_load_val`=0xA5 in cycle 1 only; `done`=1 with `aborted`=0 in cycle 2; counter reads 0xA5.
- STEP_UP N=3, P=0 → `cnt_en` high in cycles 1, 2, 3 with `cnt_up`=1; `done` in cycle 4. From a preload of 0xFE, the counter ends at 0x01 (wraps).
- STEP_DOWN N=2, P=4 → `cnt_en` in cycles 5 and 10 with `cnt_up`=0; `done` in cycle 11; `busy`=1 for cycles 1–11.
- STEP_UP N=10, P=1, then ABORT presented at cycle 6 (a step-due cycle) → `cmd_ready`=1 for ABORT only; exactly 3 `cnt_en` pulses (cycles 2, 4, 6); `done`=`aborted`=1 in cycle 7. LOAD presented during RUN → `cmd_ready`=0.
- STEP_UP N=0 → no `cnt_en`; `done`=1 with `aborted`=0 in cycle 1. ABORT in IDLE → `done`=`aborted`=1 in cycle 1.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for the 8-bit counter.
// Accepts LOAD / STEP_UP / STEP_DOWN / ABORT commands over valid/ready.
// Drives the counter's load, enable and direction controls.
// Steps are paced by a programmable prescaler, and a one-cycle done pulse
// marks completion.
module counter_sequencer #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [7:0]            cmd_data,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  cnt_load,
  output logic [7:0]            cnt_load_val,
  output logic                  cnt_en,
  output logic                  cnt_up,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  state_t                state;
  logic [7:0]            remaining;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] pc;
  logic [PRESCALE_W-1:0] pc_next;
  logic                  accept;

  // Ready depends only on state and opcode; while running, only ABORT gets in.
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      RUN:     cmd_ready = (cmd_op == OP_ABORT);
      default: cmd_ready = 1'b0;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;

  // Prescale phase for the next cycle; equality wrap makes an all-ones period legal.
  always_comb begin
    pc_next = (pc == period) ? '0 : pc + PRESCALE_W'(1);
  end

  // Main sequencer: state, step bookkeeping and all registered outputs.
  // cnt_en is registered one cycle ahead from pc_next, so a strobe lands exactly
  // on cycles k*(P+1). remaining drops at the end of each strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      period       <= '0;
      pc           <= '0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_en       <= 1'b0;
      cnt_up       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      cnt_load <= 1'b0;
      cnt_en   <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            case (cmd_op)
              OP_LOAD: begin
                state        <= LOAD;
                cnt_load     <= 1'b1;
                cnt_load_val <= cmd_data;
              end
              OP_UP, OP_DOWN: begin
                cnt_up <= (cmd_op == OP_UP);
                if (cmd_data == 8'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state     <= RUN;
                  remaining <= cmd_data;
                  period    <= prescale;
                  pc        <= '0;
                  cnt_en    <= (prescale == '0);
                end
              end
              default: begin
                state   <= DONE;
                done    <= 1'b1;
                aborted <= 1'b1;
              end
            endcase
          end
        end
        LOAD: begin
          state <= DONE;
          done  <= 1'b1;
        end
        RUN: begin
          if (accept) begin
            state   <= DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (cnt_en && (remaining == 8'd1)) begin
            state     <= DONE;
            done      <= 1'b1;
            remaining <= '0;
          end else begin
            if (cnt_en) begin
              remaining <= remaining - 8'd1;
            end
            pc     <= pc_next;
            cnt_en <= (pc_next == period);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: table-driven, hand-written and randomized checks of
// counter_sequencer against a schedule-based reference model.
// On each accepted command, the model expands the command into a per-cycle
// list of expected outputs using plain arithmetic.
module tb_counter_sequencer;

  localparam int PW = 8;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_ABORT = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic [PW-1:0] prescale;
  logic          cnt_load;
  logic [7:0]    cnt_load_val;
  logic          cnt_en;
  logic          cnt_up;
  logic          busy;
  logic          done;
  logic          aborted;

  counter_sequencer #(.PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .prescale     (prescale),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // phase: 0 idle, 1 load strobe, 2 stepping, 3 completion
  typedef struct {
    int phase;
    bit load;
    bit en;
    bit dn;
    bit ab;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] pre;
    int         done_cyc;
    int         en_cnt;
    int         first_en;
    bit         ab;
    bit         up;
  } vec_t;

  exp_t       sched[$];
  logic       exp_up;
  logic [7:0] exp_load_val;

  int n_checks;
  int n_fail;

  int cycle_idx;
  int en_count;
  int en_cycles[$];
  bit saw_done;
  int done_cycle;
  bit done_aborted;
  bit last_ready;

  vec_t vecs[7];

  function automatic exp_t mk(input int ph, input bit ld, input bit en, input bit dn, input bit ab);
    exp_t e;
    e.phase = ph;
    e.load  = ld;
    e.en    = en;
    e.dn    = dn;
    e.ab    = ab;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, expv, cycle_idx, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [7:0] d,
                               input logic [PW-1:0] p, input bit r);
    exp_t        cur;
    bit          exp_ready;
    bit          acc;
    logic [14:0] act;
    logic [14:0] expv;
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    prescale  = p;
    #1;
    cur = (sched.size() > 0) ? sched[0] : mk(0, 0, 0, 0, 0);
    exp_ready = (cur.phase == 0) || ((cur.phase == 2) && (op == OP_ABORT));
    act  = {cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, aborted};
    expv = {exp_ready, cur.load, exp_load_val, cur.en, exp_up, (cur.phase != 0), cur.dn, cur.ab};
    checkOutput("cycle outputs {rdy,ld,ldval,en,up,busy,done,ab}", 32'(act), 32'(expv));
    last_ready = cmd_ready;
    if (cnt_en === 1'b1) begin
      en_count++;
      en_cycles.push_back(cycle_idx);
    end
    if ((done === 1'b1) && !saw_done) begin
      saw_done     = 1'b1;
      done_cycle   = cycle_idx;
      done_aborted = aborted;
    end
    @(posedge clk);
    acc = v && exp_ready && !r;
    if (r) begin
      sched.delete();
      exp_up       = 1'b0;
      exp_load_val = 8'h00;
    end else begin
      if (sched.size() > 0) begin
        void'(sched.pop_front());
      end
      if (acc && (cur.phase == 2)) begin
        sched.delete();
        sched.push_back(mk(3, 0, 0, 1, 1));
      end else if (acc) begin
        cycle_idx = 0;
        en_count  = 0;
        en_cycles.delete();
        saw_done  = 1'b0;
        case (op)
          OP_LOAD: begin
            exp_load_val = d;
            sched.push_back(mk(1, 1, 0, 0, 0));
            sched.push_back(mk(3, 0, 0, 1, 0));
          end
          OP_UP, OP_DOWN: begin
            exp_up = (op == OP_UP);
            for (int c = 1; c <= int'(d) * (int'(p) + 1); c++) begin
              sched.push_back(mk(2, 0, (c % (int'(p) + 1)) == 0, 0, 0));
            end
            sched.push_back(mk(3, 0, 0, 1, 0));
          end
          default: sched.push_back(mk(3, 0, 0, 1, 1));
        endcase
      end
    end
    cycle_idx++;
    @(negedge clk);
  endtask

  task automatic idleUntilDone(input int budget);
    for (int k = 0; k < budget && !saw_done; k++) begin
      applyStimulus(0, OP_LOAD, 8'h00, '0, 0);
    end
    checkOutput("done within budget", 32'(saw_done), 32'd1);
  endtask

  // Top-level sequence: table vectors, hand-written corners, then random traffic.
  initial begin
    logic       rv;
    logic       rr;
    logic [1:0] rop;
    logic [7:0] rd;
    logic [7:0] rp;

    n_checks     = 0;
    n_fail       = 0;
    cycle_idx    = 0;
    en_count     = 0;
    saw_done     = 1'b0;
    done_cycle   = -1;
    done_aborted = 1'b0;
    exp_up       = 1'b0;
    exp_load_val = 8'h00;

    vecs[0] = '{OP_LOAD,  8'hA5, 8'd0,   2,   0, -1, 1'b0, 1'b0};
    vecs[1] = '{OP_UP,    8'd3,  8'd0,   4,   3,  1, 1'b0, 1'b1};
    vecs[2] = '{OP_UP,    8'd0,  8'd2,   1,   0, -1, 1'b0, 1'b1};
    vecs[3] = '{OP_ABORT, 8'h5A, 8'd1,   1,   0, -1, 1'b1, 1'b1};
    vecs[4] = '{OP_DOWN,  8'd2,  8'd4,  11,   2,  5, 1'b0, 1'b0};
    vecs[5] = '{OP_UP,    8'd1,  8'd255, 257, 1, 256, 1'b0, 1'b1};
    vecs[6] = '{OP_DOWN,  8'd4,  8'd2,  13,   4,  3, 1'b0, 1'b0};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'h00;
    prescale  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, vecs[i].op, vecs[i].data, vecs[i].pre, 0);
      idleUntilDone(400);
      checkOutput("table done cycle", 32'(done_cycle), 32'(vecs[i].done_cyc));
      checkOutput("table cnt_en count", 32'(en_count), 32'(vecs[i].en_cnt));
      checkOutput("table first cnt_en cycle", 32'((en_cycles.size() > 0) ? en_cycles[0] : -1),
                  32'(vecs[i].first_en));
      checkOutput("table aborted", 32'(done_aborted), 32'(vecs[i].ab));
      checkOutput("table cnt_up", 32'(cnt_up), 32'(vecs[i].up));
    end

    // ABORT on a step-due cycle; LOAD presented during RUN must be refused.
    applyStimulus(1, OP_UP, 8'd10, 8'd1, 0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1, OP_LOAD, 8'h77, 8'd0, 0);
      if (c == 3) checkOutput("ready for LOAD in RUN", 32'(last_ready), 32'd0);
    end
    applyStimulus(1, OP_ABORT, 8'h00, 8'd0, 0);
    checkOutput("ready for ABORT in RUN", 32'(last_ready), 32'd1);
    idleUntilDone(50);
    checkOutput("abort cnt_en count", 32'(en_count), 32'd3);
    checkOutput("abort last cnt_en cycle",
                32'((en_cycles.size() > 0) ? en_cycles[en_cycles.size() - 1] : -1), 32'd6);
    checkOutput("abort done cycle", 32'(done_cycle), 32'd7);
    checkOutput("abort aborted flag", 32'(done_aborted), 32'd1);

    // Reset mid-RUN after five steps; nothing may continue afterwards.
    applyStimulus(1, OP_UP, 8'd200, 8'd3, 0);
    for (int k = 0; k < 100 && en_count < 5; k++) begin
      applyStimulus(0, OP_LOAD, 8'h00, 8'd0, 0);
    end
    checkOutput("five steps before reset", 32'(en_count), 32'd5);
    applyStimulus(1, OP_LOAD, 8'h33, 8'd0, 1);
    applyStimulus(0, OP_LOAD, 8'h00, 8'd0, 0);
    checkOutput("ready after reset", 32'(last_ready), 32'd1);
    for (int k = 0; k < 30; k++) begin
      applyStimulus(0, OP_LOAD, 8'h00, 8'd0, 0);
    end
    checkOutput("no cnt_en after reset", 32'(en_count), 32'd5);

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      rr  = ($urandom_range(0, 199) == 0);
      rv  = 1'($urandom_range(0, 1));
      rop = 2'($urandom_range(0, 3));
      if (rop == OP_LOAD) rd = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 19) == 0) rd = 8'($urandom_range(6, 20));
      else rd = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) rp = 8'($urandom_range(4, 12));
      else rp = 8'($urandom_range(0, 3));
      applyStimulus(rv, rop, rd, rp, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
